// File: rtl/lz77_pkg.sv
// rtl/lz77_pkg.sv - shared widths, search buffer geometry and decoder state enum for the LZ77 blocks
package lz77_pkg;

   localparam int DATA_W     = 8;
   localparam int POS_W      = 4;
   localparam int LEN_W      = 3;
   localparam int SEARCH_LEN = 9;

   localparam logic [DATA_W-1:0] END_CHAR = 8'h24;
   localparam logic [POS_W-1:0]  LAST_POS = POS_W'(SEARCH_LEN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      COPY = 2'd1,
      LIT  = 2'd2,
      DONE = 2'd3
   } dec_state_t;

   function automatic logic pos_in_range(input logic [POS_W-1:0] pos);
      return pos <= LAST_POS;
   endfunction

endpackage

// File: rtl/lz77_decoder_if.sv
// rtl/lz77_decoder_if.sv - code triple input handshake and decoded character output of the LZ77 decoder
interface lz77_decoder_if;
   import lz77_pkg::*;

   logic              code_valid;
   logic              code_ready;
   logic [POS_W-1:0]  code_pos;
   logic [LEN_W-1:0]  code_len;
   logic [DATA_W-1:0] chardata;
   logic              valid;
   logic [DATA_W-1:0] char_nxt;

   modport slave (
      input  code_valid, code_pos, code_len, chardata,
      output code_ready, valid, char_nxt
   );

   modport master (
      output code_valid, code_pos, code_len, chardata,
      input  code_ready, valid, char_nxt
   );

endinterface

// File: rtl/lz77_search_buf.sv
// rtl/lz77_search_buf.sv - SEARCH_LEN deep history shift register with a combinational read port
module lz77_search_buf
   import lz77_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              shift_en,
   input  logic [DATA_W-1:0] din,
   input  logic [POS_W-1:0]  rd_pos,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] sbuf [SEARCH_LEN];

   // sbuf[0] is always the most recently emitted character
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SEARCH_LEN; i++) sbuf[i] <= '0;
      end else if (shift_en) begin
         sbuf[0] <= din;
         for (int i = 1; i < SEARCH_LEN; i++) sbuf[i] <= sbuf[i-1];
      end
   end

   assign rd_data = pos_in_range(rd_pos) ? sbuf[rd_pos] : '0;

endmodule

// File: rtl/lz77_decoder.sv
// rtl/lz77_decoder.sv - LZ77 (pos,len,char) decoder, one char per cycle; LZ77_DEC_CHECK_EN adds sticky err output
module lz77_decoder
   import lz77_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   lz77_decoder_if.slave  cif,
   output logic           encode,
   output logic           finish
`ifdef LZ77_DEC_CHECK_EN
   ,
   output logic           err
`endif
);

   dec_state_t        state;
   logic [POS_W-1:0]  pos;
   logic [LEN_W-1:0]  rem;
   logic [DATA_W-1:0] lit;
   logic              shift_en;
   logic [DATA_W-1:0] shift_din;
   logic [DATA_W-1:0] rd_data;
   logic              handshake;

   assign cif.code_ready = (state == IDLE) && !reset;
   assign handshake      = cif.code_valid && cif.code_ready;
   assign encode         = 1'b0;

   // Every emitted char, copied or literal, becomes new history
   assign shift_en  = (state == COPY) || (state == LIT);
   assign shift_din = (state == COPY) ? rd_data : lit;

   lz77_search_buf u_search_buf (
      .clk      (clk),
      .reset    (reset),
      .shift_en (shift_en),
      .din      (shift_din),
      .rd_pos   (pos),
      .rd_data  (rd_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         pos          <= '0;
         rem          <= '0;
         lit          <= '0;
         cif.valid    <= 1'b0;
         cif.char_nxt <= '0;
         finish       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cif.valid <= 1'b0;
               if (handshake) begin
                  pos   <= cif.code_pos;
                  rem   <= cif.code_len;
                  lit   <= cif.chardata;
                  state <= (cif.code_len != '0) ? COPY : LIT;
               end
            end
            // pos stays fixed; the shift makes overlapping copies repeat the run
            COPY: begin
               cif.valid    <= 1'b1;
               cif.char_nxt <= rd_data;
               rem          <= rem - 1'b1;
               if (rem == LEN_W'(1)) state <= LIT;
            end
            LIT: begin
               cif.valid    <= 1'b1;
               cif.char_nxt <= lit;
               if (lit == END_CHAR) begin
                  state  <= DONE;
                  finish <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            DONE: begin
               cif.valid <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               cif.valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef LZ77_DEC_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err <= 1'b0;
      end else if ((handshake && (cif.code_len != '0) && !pos_in_range(cif.code_pos)) ||
                   ((state == DONE) && cif.code_valid)) begin
         err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_lz77_decoder.sv
// tb/tb_lz77_decoder.sv - directed table-driven bench for lz77_decoder
module tb_lz77_decoder;
   import lz77_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic encode;
   logic finish;
`ifdef LZ77_DEC_CHECK_EN
   logic err;
`endif

   always #5 clk = ~clk;

   lz77_decoder_if dif();

   lz77_decoder dut (
      .clk    (clk),
      .reset  (reset),
      .cif    (dif),
      .encode (encode),
      .finish (finish)
`ifdef LZ77_DEC_CHECK_EN
      ,
      .err    (err)
`endif
   );

   typedef struct {
      logic              rst;
      logic [POS_W-1:0]  pos;
      logic [LEN_W-1:0]  len;
      logic [DATA_W-1:0] ch;
      logic [63:0]       exp;
   } vec_t;

   vec_t vecs[15];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset          = 1'b1;
      dif.code_valid = 1'b0;
      @(negedge clk);
      check("ready_during_reset", 32'(dif.code_ready), 32'd0);
      reset = 1'b0;
      #1;
      check("rst_valid", 32'(dif.valid), 32'd0);
      check("rst_char", 32'(dif.char_nxt), 32'd0);
      check("rst_finish", 32'(finish), 32'd0);
      check("rst_encode", 32'(encode), 32'd0);
      check("rst_ready", 32'(dif.code_ready), 32'd1);
`ifdef LZ77_DEC_CHECK_EN
      check("rst_err", 32'(err), 32'd0);
`endif
   endtask

   // Expected chars are left-aligned in exp, first output char in the top byte
   task automatic run_code(input string nm, input logic [POS_W-1:0] pos, input logic [LEN_W-1:0] len,
                           input logic [DATA_W-1:0] ch, input logic [63:0] exp);
      check($sformatf("%s_ready", nm), 32'(dif.code_ready), 32'd1);
      dif.code_valid = 1'b1;
      dif.code_pos   = pos;
      dif.code_len   = len;
      dif.chardata   = ch;
      @(posedge clk);
      @(negedge clk);
      dif.code_valid = 1'b0;
      for (int k = 0; k <= int'(len); k++) begin
         @(negedge clk);
         check($sformatf("%s_valid%0d", nm, k), 32'(dif.valid), 32'd1);
         check($sformatf("%s_char%0d", nm, k), 32'(dif.char_nxt), 32'(exp[63-8*k -: 8]));
      end
   endtask

   initial begin
      logic [7:0] c;
      reset          = 1'b1;
      dif.code_valid = 1'b0;
      dif.code_pos   = '0;
      dif.code_len   = '0;
      dif.chardata   = '0;

      vecs[0] = '{1'b1, 4'd0,  3'd0, "a", {"a", 56'd0}};
      vecs[1] = '{1'b0, 4'd0,  3'd0, "b", {"b", 56'd0}};
      vecs[2] = '{1'b0, 4'd1,  3'd3, "c", {"abac", 32'd0}};
      vecs[3] = '{1'b1, 4'd4,  3'd2, "x", {16'h0000, "x", 40'd0}};
      for (int i = 0; i < 9; i++) begin
         c = 8'(8'h31 + i);
         vecs[4+i] = '{(i == 0), 4'd0, 3'd0, c, {c, 56'd0}};
      end
      vecs[13] = '{1'b0, 4'd8,  3'd7, "z", "1234567z"};
      vecs[14] = '{1'b1, 4'd12, 3'd3, "k", {24'd0, "k", 32'd0}};

      for (int i = 0; i < 15; i++) begin
         if (vecs[i].rst) apply_reset();
         run_code($sformatf("vec%0d", i), vecs[i].pos, vecs[i].len, vecs[i].ch, vecs[i].exp);
`ifdef LZ77_DEC_CHECK_EN
         check($sformatf("vec%0d_err", i), 32'(err), (i == 14) ? 32'd1 : 32'd0);
`endif
      end

      // End marker: finish on the same edge as '$', then the decoder ignores input
      apply_reset();
      run_code("end", 4'd0, 3'd0, END_CHAR, {END_CHAR, 56'd0});
      check("end_finish", 32'(finish), 32'd1);
      dif.code_valid = 1'b1;
      dif.code_len   = 3'd0;
      dif.chardata   = "w";
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         check($sformatf("done_ready%0d", n), 32'(dif.code_ready), 32'd0);
         check($sformatf("done_valid%0d", n), 32'(dif.valid), 32'd0);
         check($sformatf("done_finish%0d", n), 32'(finish), 32'd1);
      end
`ifdef LZ77_DEC_CHECK_EN
      check("done_err", 32'(err), 32'd1);
`endif
      dif.code_valid = 1'b0;

      // Reset in the middle of a long copy
      apply_reset();
      dif.code_valid = 1'b1;
      dif.code_pos   = 4'd0;
      dif.code_len   = 3'd5;
      dif.chardata   = "m";
      @(posedge clk);
      @(negedge clk);
      dif.code_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_valid", 32'(dif.valid), 32'd0);
      check("abort_char", 32'(dif.char_nxt), 32'd0);
      check("abort_finish", 32'(finish), 32'd0);
      reset = 1'b0;
      #1;
      run_code("post_q", 4'd0, 3'd0, "q", {"q", 56'd0});
      run_code("post_r", 4'd0, 3'd1, "r", {"qr", 48'd0});
      @(negedge clk);
      check("idle_valid", 32'(dif.valid), 32'd0);
      check("idle_char_hold", 32'(dif.char_nxt), 32'("r"));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
